// File: rtl/dot_product_engine.sv
// Dot-product engine: streams A[i], B[i] from data memory and accumulates sum(A[i]*B[i]).
// Latency: 3 cycles per element plus 1 (DONE); start accepted only in IDLE, no backpressure.
module dot_product_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0]  ONE        = LEN_WIDTH'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr_a, ptr_b;
    logic [LEN_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   opa;

    logic [ADDR_WIDTH-1:0]   base_a_al, base_b_al, ptr_a_nxt, ptr_b_nxt;
    logic [LEN_WIDTH-1:0]    cnt_nxt;
    logic [2*DATA_WIDTH-1:0] opa_x, rd_x, prod;
    logic [DATA_WIDTH-1:0]   prod_lo, sum;
    logic                    prod_ovf, add_ovf;

    assign base_a_al = {base_a[ADDR_WIDTH-1:2], 2'b00};
    assign base_b_al = {base_b[ADDR_WIDTH-1:2], 2'b00};
    assign ptr_a_nxt = ptr_a + WORD_BYTES;
    assign ptr_b_nxt = ptr_b + WORD_BYTES;
    assign cnt_nxt   = cnt - ONE;

    // Sign-extend to full width so the low 2*DATA_WIDTH bits of the product are the signed product.
    assign opa_x    = {{DATA_WIDTH{opa[DATA_WIDTH-1]}}, opa};
    assign rd_x     = {{DATA_WIDTH{mem_rdata[DATA_WIDTH-1]}}, mem_rdata};
    assign prod     = opa_x * rd_x;
    assign prod_lo  = prod[DATA_WIDTH-1:0];
    assign prod_ovf = (|prod[2*DATA_WIDTH-1:DATA_WIDTH-1]) & ~(&prod[2*DATA_WIDTH-1:DATA_WIDTH-1]);
    assign sum      = result + prod_lo;
    assign add_ovf  = (result[DATA_WIDTH-1] == prod_lo[DATA_WIDTH-1]) &&
                      (sum[DATA_WIDTH-1] != result[DATA_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr_a    <= '0;
            ptr_b    <= '0;
            cnt      <= '0;
            opa      <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr_a    <= base_a_al;
                        ptr_b    <= base_b_al;
                        cnt      <= length;
                        result   <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RD_A;
                            mem_rd   <= 1'b1;
                            mem_addr <= base_a_al;
                        end
                    end
                end
                RD_A: begin
                    state    <= RD_B;
                    mem_rd   <= 1'b1;
                    mem_addr <= ptr_b;
                end
                RD_B: begin
                    opa      <= mem_rdata;
                    state    <= MAC;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
                MAC: begin
                    result   <= sum;
                    overflow <= overflow | prod_ovf | add_ovf;
                    ptr_a    <= ptr_a_nxt;
                    ptr_b    <= ptr_b_nxt;
                    cnt      <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD_A;
                        mem_rd   <= 1'b1;
                        mem_addr <= ptr_a_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_engine.sv
// Randomized self-checking bench for dot_product_engine against a plain-arithmetic reference model.
module tb_dot_product_engine;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_a, base_b;
    logic [7:0]  length;
    logic        mem_rd, busy, done, overflow;
    logic [31:0] mem_addr, mem_rdata, result;

    logic [31:0] mem [0:255];
    logic [31:0] rd_q [$];
    int          n_vec = 0, n_bad = 0, done_cnt = 0;
    bit          mon_en = 1'b0;

    dot_product_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
        .length(length), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Data memory: one-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr[9:2]] : $urandom;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd) rd_q.push_back(mem_addr);
            else check_val("addr_dflt", mem_addr, 0);
            if (done) done_cnt++;
        end
    end

    function automatic void model(input logic [31:0] ba, input logic [31:0] bb, input int n,
                                  output logic [31:0] res, output bit ovf);
        logic [31:0] pa, pb;
        longint p, s;
        pa = {ba[31:2], 2'b00};
        pb = {bb[31:2], 2'b00};
        res = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(mem[pa[9:2]])) * longint'($signed(mem[pb[9:2]]));
            if (p > 64'sd2147483647 || p < -64'sd2147483648) ovf = 1'b1;
            s = longint'($signed(res)) + longint'($signed(p[31:0]));
            if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
            res = s[31:0];
            pa += 4;
            pb += 4;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [31:0] ba, input logic [31:0] bb, input int n,
                           input bit inject, input bit chk_addr,
                           output logic [31:0] dut_res, output logic dut_ovf);
        logic [31:0] er, ea;
        bit eo;
        int cyc;
        model(ba, bb, n, er, eo);
        rd_q.delete();
        base_a = ba; base_b = bb; length = 8'(n); start = 1'b1;
        tick();
        start = 1'b0; base_a = $urandom; base_b = $urandom; length = 8'($urandom);
        check_val("busy_acc", busy, 1);
        cyc = 1;
        while (!done && cyc < 1000) begin
            if (inject && cyc == 2) begin
                start = 1'b1; base_a = $urandom; base_b = $urandom; length = 8'($urandom);
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check_val("latency", cyc, 3 * n + 1);
        check_val("done", done, 1);
        check_val("busy_done", busy, 1);
        check_val("result", result, er);
        check_val("overflow", overflow, eo);
        dut_res = result;
        dut_ovf = overflow;
        if (chk_addr) begin
            check_val("n_reads", rd_q.size(), 2 * n);
            for (int i = 0; i < rd_q.size() && i < 2 * n; i++) begin
                ea = {((i % 2) ? bb[31:2] : ba[31:2]), 2'b00} + 32'(4 * (i / 2));
                check_val("rd_addr", rd_q[i], ea);
            end
        end
        tick();
        check_val("busy_after", busy, 0);
        check_val("done_pulse", done, 0);
        check_val("result_held", result, er);
    endtask

    task automatic load_ab(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
        mem[4] = b0; mem[5] = b1; mem[6] = b2; mem[7] = b3;
    endtask

    initial begin
        logic [31:0] r;
        logic        o;
        int          dc, cyc;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1'b1; start = 1'b0; base_a = 0; base_b = 0; length = 0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_mem_rd", mem_rd, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_result", result, 0);
        check_val("rst_ovf", overflow, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_vec(0, 16, 4, 0, 1, r, o);
        check_val("b1_res", r, 70);
        check_val("b1_ovf", o, 0);

        load_ab(5, 2, 34, 4, 567, 6, 1000, 0);
        run_vec(0, 16, 4, 0, 1, r, o);
        check_val("mixed_res", r, 36847);

        run_vec(0, 16, 0, 0, 1, r, o);
        check_val("n0_res", r, 0);

        load_ab(32'h7FFF_FFFF, 1, 0, 0, 2, 1, 0, 0);
        run_vec(0, 16, 2, 0, 1, r, o);
        check_val("ovf_res", r, 32'hFFFF_FFFF);
        check_val("ovf_flag", o, 1);
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_vec(0, 16, 4, 0, 1, r, o);
        check_val("ovf_clear", o, 0);

        // Reset during the second MAC of a bench-1 run.
        dc = done_cnt;
        base_a = 0; base_b = 16; length = 4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_val("mid_mac_rd", mem_rd, 0);
        check_val("mid_partial", result, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_busy", busy, 0);
        check_val("mid_result", result, 0);
        check_val("mid_done", done, 0);
        repeat (15) tick();
        check_val("mid_no_done", done_cnt, dc);
        run_vec(0, 16, 4, 0, 1, r, o);
        check_val("restart_res", r, 70);

        run_vec(0, 16, 4, 1, 1, r, o);
        check_val("inject_res", r, 70);
        run_vec(3, 19, 4, 0, 1, r, o);
        check_val("misalign_res", r, 70);

        // Reset wins over start on the same edge.
        reset = 1'b1; start = 1'b1; length = 4;
        tick();
        reset = 1'b0; start = 1'b0;
        check_val("rst_dom_busy", busy, 0);
        tick();

        // start held through DONE is only taken on the following IDLE edge.
        base_a = 0; base_b = 16; length = 1; start = 1'b1;
        tick();
        repeat (3) tick();
        check_val("b2b_done", done, 1);
        tick();
        check_val("b2b_idle_busy", busy, 0);
        tick();
        start = 1'b0;
        check_val("b2b_rebusy", busy, 1);
        cyc = 1;
        while (!done && cyc < 100) begin tick(); cyc++; end
        check_val("b2b_latency", cyc, 4);
        check_val("b2b_res", result, 5);
        tick();

        // Pointer wrap across the top of the address space.
        for (int i = 0; i < 256; i++) mem[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
        run_vec(32'hFFFF_FFF4, 32'h0000_0FF9, 5, 0, 1, r, o);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = (t % 3 == 0) ? $urandom : 32'($urandom_range(0, 200000)) - 32'd100000;
            run_vec($urandom, $urandom, $urandom_range(0, 10), $urandom_range(0, 1), 1, r, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Memory-side dot-product accelerator that reads two word vectors out of the CPU data memory and accumulates their inner product. It replaces the software load/multiply/add loop that leaves its result in `$s6`. The engine sits beside `MIPS_CPU` on the data-memory read port. A start/done handshake launches it and reports completion, and the 32-bit result is held on a register output.

## Interface
- `DATA_WIDTH`, 32: element and accumulator width.
- `ADDR_WIDTH`, 32: byte-address width of the memory port.
- `LEN_WIDTH`, 8: width of the element-count input; maximum vector length is 2^LEN_WIDTH − 1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request, sampled only in IDLE.
- `base_a`  in  ADDR_WIDTH  byte address of A[0]. Bits [1:0] are ignored.
- `base_b`  in  ADDR_WIDTH  byte address of B[0]. Bits [1:0] are ignored.
- `length`  in  LEN_WIDTH  number of elements N.
- `mem_rd`  out  1  read strobe to data memory.
- `mem_addr`  out  ADDR_WIDTH  word-aligned byte address of the read.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after `mem_rd`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  DATA_WIDTH  accumulated sum.
- `overflow`  out  1  sticky signed-overflow flag for the current run.

## Operation
- **States:** IDLE, RD_A, RD_B, MAC, DONE.
- **IDLE, `start`=1:**
  - Latch `ptr_a = {base_a[..:2],2'b00}`, `ptr_b` likewise, and `cnt = length`.
  - Clear `result` and `overflow`.
  - Go to DONE if `length == 0`, otherwise go to RD_A.
- **RD_A:** drive `mem_rd=1` and `mem_addr=ptr_a`, then go to RD_B.
- **RD_B:**
  - Drive `mem_rd=1` and `mem_addr=ptr_b`.
  - On the edge, register `opa = mem_rdata` (data for the RD_A request), then go to MAC.
- **MAC:**
  - `mem_rd=0`.
  - On the edge: `result <= result + (opa * mem_rdata)`, keeping the low DATA_WIDTH bits.
  - On the same edge: `ptr_a += 4`, `ptr_b += 4`, `cnt -= 1`.
  - Go to DONE if the new `cnt` is 0, otherwise go to RD_A.
- **DONE:** `done=1` for this single cycle, then go to IDLE.
- **Arithmetic:**
  - Operands are signed two's complement. The product is formed at full 2·DATA_WIDTH width.
  - `overflow` sets, and stays set, if the product does not fit in DATA_WIDTH signed bits.
  - `overflow` also sets if the signed addition overflows.
  - `result` wraps modulo 2^DATA_WIDTH.
- **Address wrap:** pointers wrap modulo 2^ADDR_WIDTH with no error.
- **Held outputs:** `result` and `overflow` keep their values after DONE until the next accepted `start`.
- **Ignored inputs:**
  - `start` is ignored outside IDLE.
  - `base_a`, `base_b` and `length` changes after acceptance have no effect.
- **Output defaults:** `mem_addr` is 0 whenever `mem_rd=0`.

## Timing
- **Reset values:**
  - State is IDLE.
  - `busy`, `done`, `mem_rd`, `overflow` = 0.
  - `mem_addr`, `result` = 0.
  - Internal pointers, `cnt` and `opa` = 0.
- **Reset mid-run:** returns to IDLE on the next edge. No `done` pulse is issued and the partial `result` is cleared.
- **Reset dominance:** `reset` overrides `start` on the same edge.
- **Acceptance edge:** the edge where IDLE samples `start=1`.
- **Per element:** exactly 3 cycles (RD_A, RD_B, MAC) and exactly 2 reads.
- **Latency:** `done` is high in the cycle 3N+1 cycles after the acceptance edge. For N=0 this is the cycle immediately after.
- **busy:** high from the cycle after acceptance through the DONE cycle inclusive. It is low in the cycle after DONE.
- **Back-to-back runs:** a `start` held high during DONE is not accepted. It is accepted on the first IDLE edge, so the minimum gap between `done` and the next `busy` is 1 cycle.
- **Result visibility:** `result` reflects the final sum no later than the DONE cycle.

## Test plan
- **Vectors 1–4 by 5–8:**
  - Stimulus: A=[1,2,3,4] at words 0–3, B=[5,6,7,8] at words 4–7, `base_a`=0, `base_b`=16, N=4, `start` pulse.
  - Response: `done` 13 cycles after acceptance, `result`=70, `overflow`=0.
  - Read addresses in order: 0,16,4,20,8,24,12,28.
- **Mixed-magnitude vectors:**
  - Stimulus: A=[5,2,34,4], B=[567,6,1000,0], same bases.
  - Response: `result`=36847, `overflow`=0.
- **N=0:**
  - Response: `done` in the cycle after acceptance, `result`=0, no `mem_rd` ever asserted.
- **Overflow:**
  - Stimulus: A=[0x7FFFFFFF,1], B=[2,1].
  - Response: `overflow`=1, `result`=0xFFFFFFFF (wrapped).
  - A following run on the bench-1 data must show `overflow`=0.
- **Reset mid-run:**
  - Stimulus: assert `reset` for 1 cycle during the second MAC of the bench-1 run.
  - Response: IDLE next cycle, `busy`=0, `result`=0, no `done`.
  - A restart must produce 70.
- **start during busy / misaligned bases:**
  - Stimulus: pulse `start` during RD_B with different bases.
  - Response: ignored, and the original run completes with 70.
  - Stimulus: `base_a`=3, `base_b`=19.
  - Response: reads go to 0 and 16, and the run behaves identically to bench 1.
